// File: rtl/acl_tilt_filter_pkg.sv
// tilt_pkg: shared sample width, magnitude ceiling, FSM state encoding and magnitude helper
// No ports; imported by acl_tilt_filter and tilt_avg.
package tilt_pkg;
   localparam int TILT_W = 5;
   localparam int TILT_MAG_MAX = 15;
   typedef enum logic [1:0] {
      TILT_CENTER = 2'd0,
      TILT_LEFT   = 2'd1,
      TILT_RIGHT  = 2'd2
   } tilt_state_e;
   // |a| saturated to TILT_MAG_MAX; -16 is the only value whose magnitude overflows 4 bits
   function automatic logic [3:0] tilt_mag(input logic signed [TILT_W-1:0] a);
      logic signed [TILT_W-1:0] n;
      n = -a;
      return !a[TILT_W-1] ? a[3:0] : (a == 5'b10000) ? 4'(TILT_MAG_MAX) : n[3:0];
   endfunction
endpackage

// File: rtl/acl_tilt_filter_if.sv
// acl_tilt_filter_if: raw accelerometer word in, conditioned steering controls out
// Signals: acl_data[14:0] raw word, tilt_left, tilt_right, tilt_intensity[3:0], upd pulse.
// slave = the filter, master = the source/consumer around it.
interface acl_tilt_filter_if;
   logic [14:0] acl_data;
   logic        tilt_left;
   logic        tilt_right;
   logic [3:0]  tilt_intensity;
   logic        upd;
   modport master (output acl_data, input tilt_left, tilt_right, tilt_intensity, upd);
   modport slave  (input acl_data, output tilt_left, tilt_right, tilt_intensity, upd);
endinterface

// File: rtl/tilt_avg.sv
// tilt_avg: moving average of 2^AVG_LOG2 signed samples (ring buffer + running sum), built only with TILT_AVG_EN
// Ports: clk, rst (async, active high), in_valid, in_sample[4:0] signed, avg[4:0] signed (registered).
`ifdef TILT_AVG_EN
module tilt_avg import tilt_pkg::*; #(
   parameter int AVG_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [TILT_W-1:0] in_sample,
   output logic signed [TILT_W-1:0] avg
);
   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = TILT_W + AVG_LOG2;
   // pointer is at least one bit wide; for N=1 it simply never leaves 0
   localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
   localparam int RN = 1 << PW;
   logic signed [TILT_W-1:0] ring_q [RN];
   logic signed [TILT_W-1:0] ring_d [RN];
   logic signed [SW-1:0]     sum_q, sum_d;
   logic [PW-1:0]            ptr_q, ptr_d;
   logic signed [TILT_W-1:0] avg_q, avg_d;
   always_comb begin
      ring_d = ring_q;
      sum_d  = in_valid ? sum_q - SW'(ring_q[ptr_q]) + SW'(in_sample) : sum_q;
      ptr_d  = in_valid ? ((ptr_q == PW'(N-1)) ? '0 : ptr_q + 1'b1) : ptr_q;
      if (in_valid) ring_d[ptr_q] = in_sample;
      // arithmetic shift floors toward -inf
      avg_d  = TILT_W'(sum_d >>> AVG_LOG2);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_q <= '{default: '0};
         sum_q  <= '0;
         ptr_q  <= '0;
         avg_q  <= '0;
      end else begin
         ring_q <= ring_d;
         sum_q  <= sum_d;
         ptr_q  <= ptr_d;
         avg_q  <= avg_d;
      end
   end
   assign avg = avg_q;
endmodule
`endif

// File: rtl/acl_tilt_filter.sv
// acl_tilt_filter: synchronize, stability-check, average and hysteresis-filter the accelerometer X tilt
// Ports: clk, rst (async, active high), bus (acl_tilt_filter_if.slave: acl_data in; tilt_left,
// tilt_right, tilt_intensity, upd out). Optional averaging via `define TILT_AVG_EN; without it
// the average stage is a plain register so tick-to-upd latency is unchanged.
module acl_tilt_filter import tilt_pkg::*; #(
   parameter int SAMPLE_DIV = 100000,
   parameter int AVG_LOG2   = 2,
   parameter int ENTER_TH   = 4,
   parameter int EXIT_TH    = 2
) (
   input logic               clk,
   input logic               rst,
   acl_tilt_filter_if.slave  bus
);
   localparam int CW = $clog2(SAMPLE_DIV);
   localparam logic signed [TILT_W-1:0] ENTER_P = TILT_W'(ENTER_TH);
   localparam logic signed [TILT_W-1:0] ENTER_N = TILT_W'(-ENTER_TH);
   localparam logic signed [TILT_W-1:0] EXIT_P  = TILT_W'(EXIT_TH);
   localparam logic signed [TILT_W-1:0] EXIT_N  = TILT_W'(-EXIT_TH);
   if (SAMPLE_DIV < 4 || AVG_LOG2 < 0 || AVG_LOG2 > 4 || ENTER_TH < 1 || ENTER_TH > 15 ||
       EXIT_TH < 1 || EXIT_TH > ENTER_TH) begin : g_bad_cfg
      $error("acl_tilt_filter: parameter out of legal range");
   end
   logic signed [TILT_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     tick;
   logic                     cap_v_q, cap_v_d;
   logic                     avg_v_q, avg_v_d;
   logic signed [TILT_W-1:0] avg;
   tilt_state_e              state_q, state_d;
   logic                     left_q, left_d, right_q, right_d, upd_q, upd_d;
   logic [3:0]               int_q, int_d;
   logic                     go_left, go_right;
   // s3 after the capture edge holds exactly the s2 value seen at the tick, so it is the captured sample
`ifdef TILT_AVG_EN
   tilt_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (cap_v_q),
      .in_sample (s3_q),
      .avg       (avg)
   );
`else
   logic signed [TILT_W-1:0] avg_q, avg_d;
   assign avg_d = cap_v_q ? s3_q : avg_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) avg_q <= '0;
      else     avg_q <= avg_d;
   end
   assign avg = avg_q;
`endif
   always_comb begin
      s1_d     = bus.acl_data[9:5];
      s2_d     = s1_q;
      s3_d     = s2_q;
      tick     = cnt_q == CW'(SAMPLE_DIV-1);
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      cap_v_d  = tick && (s2_q == s3_q);
      avg_v_d  = cap_v_q;
      go_left  = avg >= ENTER_P;
      go_right = avg <= ENTER_N;
      state_d  = state_q;
      if (avg_v_q) begin
         case (state_q)
            TILT_CENTER: state_d = go_right ? TILT_RIGHT : go_left ? TILT_LEFT : TILT_CENTER;
            TILT_RIGHT:  state_d = go_left ? TILT_LEFT : (avg > EXIT_N) ? TILT_CENTER : TILT_RIGHT;
            TILT_LEFT:   state_d = go_right ? TILT_RIGHT : (avg < EXIT_P) ? TILT_CENTER : TILT_LEFT;
            default:     state_d = TILT_CENTER;
         endcase
      end
      left_d   = avg_v_q ? state_d == TILT_LEFT : left_q;
      right_d  = avg_v_q ? state_d == TILT_RIGHT : right_q;
      int_d    = avg_v_q ? ((state_d == TILT_CENTER) ? 4'd0 : tilt_mag(avg)) : int_q;
      upd_d    = avg_v_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         cnt_q   <= '0;
         cap_v_q <= 1'b0;
         avg_v_q <= 1'b0;
         state_q <= TILT_CENTER;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         int_q   <= '0;
         upd_q   <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         cnt_q   <= cnt_d;
         cap_v_q <= cap_v_d;
         avg_v_q <= avg_v_d;
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         int_q   <= int_d;
         upd_q   <= upd_d;
      end
   end
   assign bus.tilt_left      = left_q;
   assign bus.tilt_right     = right_q;
   assign bus.tilt_intensity = int_q;
   assign bus.upd            = upd_q;
endmodule
